// File: rtl/kernel_pkg.sv
// Shared types and constants for the GEMM issue/collect controller and the
// adder-tree engine it feeds.
package kernel_pkg;

   localparam int VECTOR_LENGTH = 16;
   localparam int DATA_WIDTH    = 32;
   localparam int ADDR_WIDTH    = 10;
   localparam int LEN_WIDTH     = 8;
   localparam int AT_LATENCY    = 5;
   localparam int VEC_W         = VECTOR_LENGTH * DATA_WIDTH;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   typedef struct packed {
      logic                  valid;
      logic                  last;
      logic [ADDR_WIDTH-1:0] addr;
   } tag_t;

endpackage

// File: rtl/at_issue_ctrl_if.sv
// Buffer read, adder-tree and output-buffer write bundle between the issue
// controller (master) and its surrounding memories/engine (slave).
interface at_issue_ctrl_if;
   import kernel_pkg::*;

   logic                     ibuf_rd_en;
   logic [ADDR_WIDTH-1:0]    ibuf_rd_addr;
   logic [VEC_W-1:0]         ibuf_rd_data;
   logic                     wbuf_rd_en;
   logic [ADDR_WIDTH-1:0]    wbuf_rd_addr;
   logic [VEC_W-1:0]         wbuf_rd_data;
   logic [VEC_W-1:0]         at_i_data;
   logic [VEC_W-1:0]         at_w_data;
   logic [VECTOR_LENGTH-1:0] at_i_valid;
   logic [VECTOR_LENGTH-1:0] at_w_valid;
   logic                     at_accum;
   logic                     at_status;
   logic [DATA_WIDTH-1:0]    at_o_data;
   logic                     at_o_valid;
   logic                     obuf_wr_en;
   logic [ADDR_WIDTH-1:0]    obuf_wr_addr;
   logic [DATA_WIDTH-1:0]    obuf_wr_data;

   modport master (
      output ibuf_rd_en, ibuf_rd_addr, wbuf_rd_en, wbuf_rd_addr,
      output at_i_data, at_w_data, at_i_valid, at_w_valid, at_accum,
      output obuf_wr_en, obuf_wr_addr, obuf_wr_data,
      input  ibuf_rd_data, wbuf_rd_data, at_status, at_o_data, at_o_valid
   );

   modport slave (
      input  ibuf_rd_en, ibuf_rd_addr, wbuf_rd_en, wbuf_rd_addr,
      input  at_i_data, at_w_data, at_i_valid, at_w_valid, at_accum,
      input  obuf_wr_en, obuf_wr_addr, obuf_wr_data,
      output ibuf_rd_data, wbuf_rd_data, at_status, at_o_data, at_o_valid
   );

endinterface

// File: rtl/gemm_addr_gen.sv
// r/n/k loop counters (r outer, k inner) producing A, W and output addresses
// incrementally from running bases, without multipliers.
module gemm_addr_gen
   import kernel_pkg::*;
(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  load_i,
   input  logic                  advance_i,
   input  logic [LEN_WIDTH-1:0]  rows_i,
   input  logic [LEN_WIDTH-1:0]  cols_i,
   input  logic [LEN_WIDTH-1:0]  chunks_i,
   output logic [ADDR_WIDTH-1:0] ibuf_addr_o,
   output logic [ADDR_WIDTH-1:0] wbuf_addr_o,
   output logic [ADDR_WIDTH-1:0] out_addr_o,
   output logic                  first_o,
   output logic                  last_o,
   output logic                  end_o
);

   logic [LEN_WIDTH-1:0]  kmax_q, kmax_d, nmax_q, nmax_d, rmax_q, rmax_d;
   logic [LEN_WIDTH-1:0]  k_q, k_d, n_q, n_d, r_q, r_d;
   logic [ADDR_WIDTH-1:0] ia_q, ia_d, wa_q, wa_d, oa_q, oa_d, ibase_q, ibase_d;
   logic                  last_s;

   assign last_s      = (k_q == kmax_q);
   assign first_o     = (k_q == {LEN_WIDTH{1'b0}});
   assign last_o      = last_s;
   assign end_o       = last_s && (n_q == nmax_q) && (r_q == rmax_q);
   assign ibuf_addr_o = ia_q;
   assign wbuf_addr_o = wa_q;
   assign out_addr_o  = oa_q;

   // Next loop position: ibase_q holds r*K so a new column restarts the A row.
   always_comb begin
      kmax_d  = kmax_q;
      nmax_d  = nmax_q;
      rmax_d  = rmax_q;
      k_d     = k_q;
      n_d     = n_q;
      r_d     = r_q;
      ia_d    = ia_q;
      wa_d    = wa_q;
      oa_d    = oa_q;
      ibase_d = ibase_q;
      if (load_i) begin
         kmax_d  = chunks_i - LEN_WIDTH'(1);
         nmax_d  = cols_i - LEN_WIDTH'(1);
         rmax_d  = rows_i - LEN_WIDTH'(1);
         k_d     = {LEN_WIDTH{1'b0}};
         n_d     = {LEN_WIDTH{1'b0}};
         r_d     = {LEN_WIDTH{1'b0}};
         ia_d    = {ADDR_WIDTH{1'b0}};
         wa_d    = {ADDR_WIDTH{1'b0}};
         oa_d    = {ADDR_WIDTH{1'b0}};
         ibase_d = {ADDR_WIDTH{1'b0}};
      end else if (advance_i) begin
         if (!last_s) begin
            k_d  = k_q + LEN_WIDTH'(1);
            ia_d = ia_q + ADDR_WIDTH'(1);
            wa_d = wa_q + ADDR_WIDTH'(1);
         end else begin
            k_d  = {LEN_WIDTH{1'b0}};
            oa_d = oa_q + ADDR_WIDTH'(1);
            if (n_q != nmax_q) begin
               n_d  = n_q + LEN_WIDTH'(1);
               ia_d = ibase_q;
               wa_d = wa_q + ADDR_WIDTH'(1);
            end else begin
               n_d     = {LEN_WIDTH{1'b0}};
               r_d     = r_q + LEN_WIDTH'(1);
               ia_d    = ia_q + ADDR_WIDTH'(1);
               ibase_d = ia_q + ADDR_WIDTH'(1);
               wa_d    = {ADDR_WIDTH{1'b0}};
            end
         end
      end else begin
         k_d = k_q;
      end
   end

   // Counter and address registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         kmax_q  <= {LEN_WIDTH{1'b0}};
         nmax_q  <= {LEN_WIDTH{1'b0}};
         rmax_q  <= {LEN_WIDTH{1'b0}};
         k_q     <= {LEN_WIDTH{1'b0}};
         n_q     <= {LEN_WIDTH{1'b0}};
         r_q     <= {LEN_WIDTH{1'b0}};
         ia_q    <= {ADDR_WIDTH{1'b0}};
         wa_q    <= {ADDR_WIDTH{1'b0}};
         oa_q    <= {ADDR_WIDTH{1'b0}};
         ibase_q <= {ADDR_WIDTH{1'b0}};
      end else begin
         kmax_q  <= kmax_d;
         nmax_q  <= nmax_d;
         rmax_q  <= rmax_d;
         k_q     <= k_d;
         n_q     <= n_d;
         r_q     <= r_d;
         ia_q    <= ia_d;
         wa_q    <= wa_d;
         oa_q    <= oa_d;
         ibase_q <= ibase_d;
      end
   end

endmodule

// File: rtl/at_issue_ctrl.sv
// Issue/collect controller: streams A/W chunk pairs into the adder tree and
// writes each completed dot product, tracked by a tag pipeline, to the obuf.
module at_issue_ctrl
   import kernel_pkg::*;
(
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [LEN_WIDTH-1:0] num_rows,
   input  logic [LEN_WIDTH-1:0] num_cols,
   input  logic [LEN_WIDTH-1:0] num_chunks,
   output logic                 busy,
   output logic                 done,
   output logic                 err,
   at_issue_ctrl_if.master      bus
);

   state_e                state_q, state_d;
   logic                  rd_en_q, rd_en_d;
   logic                  err_q, err_d;
   logic                  load_s, adv_s, first_s, last_s, end_s, zero_s;
   logic                  pipe_busy_s, mismatch_s, wr_fire_s;
   logic [ADDR_WIDTH-1:0] ia_s, wa_s, oa_s;
   tag_t                  pres_q;
   logic                  accum_q;
   tag_t                  tag_q [AT_LATENCY];
   logic                  wr_en_q;
   logic [ADDR_WIDTH-1:0] wr_addr_q;
   logic [DATA_WIDTH-1:0] wr_data_q;

   gemm_addr_gen u_addr_gen (
      .clk         (clk),
      .reset       (reset),
      .load_i      (load_s),
      .advance_i   (adv_s),
      .rows_i      (num_rows),
      .cols_i      (num_cols),
      .chunks_i    (num_chunks),
      .ibuf_addr_o (ia_s),
      .wbuf_addr_o (wa_s),
      .out_addr_o  (oa_s),
      .first_o     (first_s),
      .last_o      (last_s),
      .end_o       (end_s)
   );

   assign zero_s = (num_rows == {LEN_WIDTH{1'b0}}) || (num_cols == {LEN_WIDTH{1'b0}}) ||
                   (num_chunks == {LEN_WIDTH{1'b0}});

   always_comb begin
      pipe_busy_s = rd_en_q | pres_q.valid;
      for (int i = 0; i < AT_LATENCY; i++) pipe_busy_s = pipe_busy_s | tag_q[i].valid;
   end

   assign mismatch_s = tag_q[AT_LATENCY-1].valid ^ bus.at_o_valid;
   assign wr_fire_s  = tag_q[AT_LATENCY-1].valid & tag_q[AT_LATENCY-1].last & bus.at_o_valid;

   // Job sequencing: issue one read pair per cycle until the final chunk, then drain.
   always_comb begin
      state_d = state_q;
      rd_en_d = 1'b0;
      load_s  = 1'b0;
      adv_s   = 1'b0;
      err_d   = err_q | mismatch_s;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               load_s = 1'b1;
               err_d  = 1'b0;
               if (zero_s) begin
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_ISSUE;
                  rd_en_d = 1'b1;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_ISSUE: begin
            if (end_s) begin
               state_d = ST_DRAIN;
            end else begin
               adv_s   = 1'b1;
               rd_en_d = 1'b1;
            end
         end
         ST_DRAIN: begin
            if (!pipe_busy_s && !bus.at_status) state_d = ST_DONE;
            else                                state_d = ST_DRAIN;
         end
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // State, read strobe, sticky error, tag pipeline and output write register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         rd_en_q   <= 1'b0;
         err_q     <= 1'b0;
         pres_q    <= '{valid: 1'b0, last: 1'b0, addr: {ADDR_WIDTH{1'b0}}};
         accum_q   <= 1'b0;
         for (int i = 0; i < AT_LATENCY; i++)
            tag_q[i] <= '{valid: 1'b0, last: 1'b0, addr: {ADDR_WIDTH{1'b0}}};
         wr_en_q   <= 1'b0;
         wr_addr_q <= {ADDR_WIDTH{1'b0}};
         wr_data_q <= {DATA_WIDTH{1'b0}};
      end else begin
         state_q  <= state_d;
         rd_en_q  <= rd_en_d;
         err_q    <= err_d;
         pres_q   <= '{valid: rd_en_q, last: last_s, addr: oa_s};
         accum_q  <= rd_en_q & ~first_s;
         tag_q[0] <= pres_q;
         for (int i = 1; i < AT_LATENCY; i++) tag_q[i] <= tag_q[i-1];
         wr_en_q  <= wr_fire_s;
         if (wr_fire_s) begin
            wr_addr_q <= tag_q[AT_LATENCY-1].addr;
            wr_data_q <= bus.at_o_data;
         end
      end
   end

   assign busy = (state_q != ST_IDLE);
   assign done = (state_q == ST_DONE);
   assign err  = err_q;

   assign bus.ibuf_rd_en   = rd_en_q;
   assign bus.ibuf_rd_addr = ia_s;
   assign bus.wbuf_rd_en   = rd_en_q;
   assign bus.wbuf_rd_addr = wa_s;
   // Buffer data flows straight through to the tree in the cycle after the read.
   assign bus.at_i_data    = pres_q.valid ? bus.ibuf_rd_data : {VEC_W{1'b0}};
   assign bus.at_w_data    = pres_q.valid ? bus.wbuf_rd_data : {VEC_W{1'b0}};
   assign bus.at_i_valid   = {VECTOR_LENGTH{pres_q.valid}};
   assign bus.at_w_valid   = {VECTOR_LENGTH{pres_q.valid}};
   assign bus.at_accum     = accum_q;
   assign bus.obuf_wr_en   = wr_en_q;
   assign bus.obuf_wr_addr = wr_addr_q;
   assign bus.obuf_wr_data = wr_data_q;

endmodule

// File: tb/tb_at_issue_ctrl.sv
// Directed bench for at_issue_ctrl with buffer and 5-stage adder-tree models.
module tb_at_issue_ctrl;
   import kernel_pkg::*;

   logic                 clk = 1'b0;
   logic                 reset = 1'b1;
   logic                 start = 1'b0;
   logic [LEN_WIDTH-1:0] num_rows = 8'd0, num_cols = 8'd0, num_chunks = 8'd0;
   logic                 busy, done, err;

   at_issue_ctrl_if bus ();

   at_issue_ctrl dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .num_rows   (num_rows),
      .num_cols   (num_cols),
      .num_chunks (num_chunks),
      .busy       (busy),
      .done       (done),
      .err        (err),
      .bus        (bus.master)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Buffer models: each chunk holds one value replicated across all lanes.
   logic [DATA_WIDTH-1:0] amem [16];
   logic [DATA_WIDTH-1:0] wmem [16];
   always @(posedge clk) begin
      if (bus.ibuf_rd_en) bus.ibuf_rd_data <= {VECTOR_LENGTH{amem[bus.ibuf_rd_addr[3:0]]}};
      if (bus.wbuf_rd_en) bus.wbuf_rd_data <= {VECTOR_LENGTH{wmem[bus.wbuf_rd_addr[3:0]]}};
   end

   // Adder-tree model: lane-wise multiply, sum, optional accumulate, 5-cycle latency.
   logic                  tv [AT_LATENCY];
   logic [DATA_WIDTH-1:0] td [AT_LATENCY];
   logic [DATA_WIDTH-1:0] tacc;
   logic [DATA_WIDTH-1:0] tsum;
   always @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < AT_LATENCY; i++) begin tv[i] <= 1'b0; td[i] <= 32'd0; end
         tacc <= 32'd0;
      end else begin
         tsum = 32'd0;
         for (int i = 0; i < VECTOR_LENGTH; i++)
            tsum = tsum + bus.at_i_data[i*DATA_WIDTH +: DATA_WIDTH] * bus.at_w_data[i*DATA_WIDTH +: DATA_WIDTH];
         if (bus.at_accum) tsum = tsum + tacc;
         if (bus.at_i_valid[0]) tacc <= tsum;
         tv[0] <= bus.at_i_valid[0];
         td[0] <= tsum;
         for (int i = 1; i < AT_LATENCY; i++) begin tv[i] <= tv[i-1]; td[i] <= td[i-1]; end
      end
   end
   always_comb begin
      bus.at_o_valid = tv[AT_LATENCY-1];
      bus.at_o_data  = td[AT_LATENCY-1];
      bus.at_status  = 1'b0;
      for (int i = 0; i < AT_LATENCY; i++) bus.at_status = bus.at_status | tv[i];
   end

   // Monitor, sampled mid-cycle; cycles are relative to the start cycle.
   int   base = 0;
   int   wr_cyc [$];
   int   wr_addr [$];
   int   wr_data [$];
   int   done_cyc, done_cnt, rd_cnt, busy_last, err_seen;
   logic [7:0] accum_hist;
   always @(negedge clk) begin
      if (bus.obuf_wr_en) begin
         wr_cyc.push_back(cyc - base);
         wr_addr.push_back(int'(bus.obuf_wr_addr));
         wr_data.push_back(int'(bus.obuf_wr_data));
      end
      if (done) begin
         if (done_cnt == 0) done_cyc = cyc - base;
         done_cnt++;
      end
      if (bus.ibuf_rd_en) rd_cnt++;
      if (busy) busy_last = cyc - base;
      if (err) err_seen = 1;
      if (bus.at_i_valid[0]) accum_hist = {accum_hist[6:0], bus.at_accum};
   end

   int n_vec = 0;
   int n_err = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic clear_rec();
      wr_cyc.delete(); wr_addr.delete(); wr_data.delete();
      done_cyc = -1; done_cnt = 0; rd_cnt = 0; busy_last = -1; err_seen = 0;
      accum_hist = 8'd0;
   endtask

   // One job: start in cycle 0; optional extra start pulse in cycle extra_at.
   task automatic run_job(input int r, input int n, input int k, input int extra_at);
      clear_rec();
      @(posedge clk); #1;
      base = cyc;
      start = 1'b1;
      num_rows = LEN_WIDTH'(r); num_cols = LEN_WIDTH'(n); num_chunks = LEN_WIDTH'(k);
      @(posedge clk); #1;
      for (int i = 1; i < 300 && done_cnt == 0; i++) begin
         if (i == extra_at) begin
            start = 1'b1;
            num_rows = 8'd1; num_cols = 8'd1; num_chunks = 8'd1;
         end else begin
            start = 1'b0;
         end
         @(posedge clk); #1;
      end
      start = 1'b0;
      if (done_cnt == 0) check_eq("timeout_done", 64'd0, 64'd1);
      repeat (4) @(posedge clk);
      #1;
   endtask

   task automatic check_2x2(input string nm);
      check_eq({nm, "_wr_cnt"}, 64'(wr_cyc.size()), 64'd4);
      if (wr_cyc.size() == 4) begin
         check_eq({nm, "_a0"}, 64'(wr_addr[0]), 64'd0);
         check_eq({nm, "_a3"}, 64'(wr_addr[3]), 64'd3);
         check_eq({nm, "_d0"}, 64'(wr_data[0]), 64'd272);
         check_eq({nm, "_d1"}, 64'(wr_data[1]), 64'd368);
         check_eq({nm, "_d2"}, 64'(wr_data[2]), 64'd624);
         check_eq({nm, "_d3"}, 64'(wr_data[3]), 64'd848);
         check_eq({nm, "_c0"}, 64'(wr_cyc[0]), 64'd9);
         check_eq({nm, "_c3"}, 64'(wr_cyc[3]), 64'd15);
      end
      check_eq({nm, "_done"}, 64'(done_cyc), 64'd16);
      check_eq({nm, "_done_cnt"}, 64'(done_cnt), 64'd1);
      check_eq({nm, "_busy_last"}, 64'(busy_last), 64'd16);
      check_eq({nm, "_accum"}, 64'(accum_hist), 64'b01010101);
      check_eq({nm, "_err"}, 64'(err_seen), 64'd0);
   endtask

   initial begin
      for (int i = 0; i < 16; i++) begin amem[i] = 32'd0; wmem[i] = 32'd0; end
      bus.ibuf_rd_data = {VEC_W{1'b0}};
      bus.wbuf_rd_data = {VEC_W{1'b0}};
      clear_rec();
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check_eq("rst_busy",  64'(busy), 64'd0);
      check_eq("rst_done",  64'(done), 64'd0);
      check_eq("rst_err",   64'(err), 64'd0);
      check_eq("rst_rd_en", 64'({bus.ibuf_rd_en, bus.wbuf_rd_en}), 64'd0);
      check_eq("rst_wr_en", 64'(bus.obuf_wr_en), 64'd0);
      check_eq("rst_valid", 64'({bus.at_i_valid, bus.at_w_valid}), 64'd0);
      check_eq("rst_accum", 64'(bus.at_accum), 64'd0);
      check_eq("rst_addr",  64'({bus.ibuf_rd_addr, bus.wbuf_rd_addr, bus.obuf_wr_addr}), 64'd0);

      // 1x1x1: 16 lanes * 2 * 3
      amem[0] = 32'd2; wmem[0] = 32'd3;
      run_job(1, 1, 1, 0);
      check_eq("t1_wr_cnt", 64'(wr_cyc.size()), 64'd1);
      if (wr_cyc.size() == 1) begin
         check_eq("t1_addr", 64'(wr_addr[0]), 64'd0);
         check_eq("t1_data", 64'(wr_data[0]), 64'd96);
         check_eq("t1_cyc",  64'(wr_cyc[0]), 64'd8);
      end
      check_eq("t1_done", 64'(done_cyc), 64'd9);
      check_eq("t1_busy_last", 64'(busy_last), 64'd9);
      check_eq("t1_err", 64'(err_seen), 64'd0);

      // 1x1x3: only the final sum 48 is written
      for (int i = 0; i < 3; i++) begin amem[i] = 32'd1; wmem[i] = 32'd1; end
      run_job(1, 1, 3, 0);
      check_eq("t2_wr_cnt", 64'(wr_cyc.size()), 64'd1);
      if (wr_cyc.size() == 1) begin
         check_eq("t2_data", 64'(wr_data[0]), 64'd48);
         check_eq("t2_cyc",  64'(wr_cyc[0]), 64'd10);
      end
      check_eq("t2_done", 64'(done_cyc), 64'd11);
      check_eq("t2_rd_cnt", 64'(rd_cnt), 64'd3);
      check_eq("t2_accum", 64'(accum_hist), 64'b00000011);

      // 2x2x2 with distinct chunk values
      amem[0] = 32'd1; amem[1] = 32'd2; amem[2] = 32'd3; amem[3] = 32'd4;
      wmem[0] = 32'd5; wmem[1] = 32'd6; wmem[2] = 32'd7; wmem[3] = 32'd8;
      run_job(2, 2, 2, 0);
      check_2x2("t3");
      check_eq("t3_rd_cnt", 64'(rd_cnt), 64'd8);

      // zero chunk count
      run_job(2, 2, 0, 0);
      check_eq("t4_done", 64'(done_cyc), 64'd1);
      check_eq("t4_busy_last", 64'(busy_last), 64'd1);
      check_eq("t4_rd_cnt", 64'(rd_cnt), 64'd0);
      check_eq("t4_wr_cnt", 64'(wr_cyc.size()), 64'd0);

      // reset in the middle of ISSUE
      clear_rec();
      @(posedge clk); #1;
      base = cyc;
      start = 1'b1; num_rows = 8'd2; num_cols = 8'd2; num_chunks = 8'd2;
      @(posedge clk); #1 start = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk); #1 reset = 1'b0;
      @(negedge clk);
      check_eq("t5_busy",  64'(busy), 64'd0);
      check_eq("t5_rd_en", 64'(bus.ibuf_rd_en), 64'd0);
      check_eq("t5_valid", 64'(bus.at_i_valid), 64'd0);
      check_eq("t5_accum", 64'(bus.at_accum), 64'd0);
      check_eq("t5_rdaddr", 64'({bus.ibuf_rd_addr, bus.wbuf_rd_addr}), 64'd0);
      clear_rec();
      repeat (20) @(posedge clk);
      #1;
      check_eq("t5_no_wr", 64'(wr_cyc.size()), 64'd0);
      check_eq("t5_no_done", 64'(done_cnt), 64'd0);
      run_job(2, 2, 2, 0);
      check_2x2("t5_rerun");

      // second start while busy must be ignored
      run_job(2, 2, 2, 3);
      check_2x2("t6");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
